// File: rtl/mod_recombine.sv
// Sequential recombiner: rebuilds quotient*div + remainder by repeated addition,
// one div per clock, saturating at 2^DW-1 with a sticky overflow flag.
module mod_recombine #(
    parameter int DW = 8,
    parameter int KW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] div,
    input  logic [DW-1:0] quotient,
    input  logic [DW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] outputval,
    output logic          overflow
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [DW+1:0] MAXV = {2'b00, {DW{1'b1}}};

    state_t        state_q, state_d;
    logic [DW:0]   acc_q, acc_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] div_q, div_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] outval_q, outval_d;
    logic          oflag_q, oflag_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [DW+1:0] sum;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        ovf_d    = ovf_q;
        outval_d = outval_q;
        oflag_d  = oflag_q;
        done_d   = 1'b0;
        sum      = {1'b0, acc_q} + {{(DW+2-KW){1'b0}}, div_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d   = div;
                    cnt_d   = quotient;
                    acc_d   = {1'b0, remainder};
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                    // Saturate rather than wrap; overflow stays set for the rest of the operation.
                    if (sum > MAXV) begin
                        acc_d = {1'b0, {DW{1'b1}}};
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[DW:0];
                    end
                end else begin
                    outval_d = acc_q[DW-1:0];
                    oflag_d  = ovf_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            ovf_q    <= 1'b0;
            outval_q <= '0;
            oflag_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            outval_q <= outval_d;
            oflag_q  <= oflag_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign outputval = outval_q;
    assign overflow  = oflag_q;

endmodule

// File: tb/tb_mod_recombine.sv
// Bench for mod_recombine: arithmetic transaction model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mod_recombine;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] div = '0;
    logic [7:0] quotient = '0;
    logic [7:0] remainder = '0;
    logic       busy, done, overflow;
    logic [7:0] outputval;

    int checks = 0;
    int errors = 0;

    mod_recombine #(.DW(8), .KW(5)) dut (
        .clock(clock), .reset(reset), .start(start), .div(div),
        .quotient(quotient), .remainder(remainder), .busy(busy),
        .done(done), .outputval(outputval), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Transaction model: an accepted start finishes quotient+1 edges later with
    // min(q*d+r, 255); starts are accepted only when no operation is pending.
    int   edge_cnt = 0;
    bit   m_active = 0;
    int   m_fin = 0;
    int   m_res = 0;
    bit   m_ovf = 0;
    bit   exp_busy = 0, exp_done = 0, exp_ovf = 0;
    int   exp_out = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 0; exp_busy = 0; exp_done = 0; exp_out = 0; exp_ovf = 0;
        end else begin
            int total;
            edge_cnt = edge_cnt + 1;
            exp_done = 0;
            if (m_active) begin
                if (edge_cnt == m_fin) begin
                    exp_out = m_res; exp_ovf = m_ovf; exp_done = 1; m_active = 0;
                end
            end else if (start) begin
                total    = int'(quotient) * int'(div) + int'(remainder);
                m_ovf    = total > 255;
                m_res    = m_ovf ? 255 : total;
                m_fin    = edge_cnt + int'(quotient) + 1;
                m_active = 1;
            end
            exp_busy = m_active;
        end
    end

    always @(negedge clock) begin
        checks++;
        if (busy !== exp_busy || done !== exp_done ||
            outputval !== 8'(exp_out) || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL cycle_model edge=%0d got busy=%b done=%b out=%0d ovf=%b expected busy=%b done=%b out=%0d ovf=%b",
                     edge_cnt, busy, done, outputval, overflow, exp_busy, exp_done, exp_out, exp_ovf);
        end
    end

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    // Drive start for one cycle; returns the index of the edge that samples it.
    task automatic launch(input int d, input int q, input int r, output int n);
        @(posedge clock); #2;
        start = 1'b1; div = 5'(d); quotient = 8'(q); remainder = 8'(r);
        n = edge_cnt + 1;
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n, input int lat,
                             input int ev, input int eo);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
        if (seen) begin
            check({name, "_latency"}, edge_cnt - n, lat);
            check({name, "_value"}, int'(outputval), ev);
            check({name, "_ovf"}, int'(overflow), eo);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done) cnt++;
        end
    endtask

    initial begin
        int n, nd;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_out", int'(outputval), 0);
        check("reset_ovf", int'(overflow), 0);

        launch(7, 5, 3, n);
        check("basic_busy_after_start", int'(busy), 1);
        wait_done("basic", n, 6, 38, 0);

        launch(9, 0, 200, n);
        wait_done("zero_q", n, 1, 200, 0);

        launch(31, 9, 5, n);
        wait_done("saturate", n, 10, 255, 1);

        launch(0, 4, 17, n);
        wait_done("div_zero", n, 5, 17, 0);

        launch(3, 2, 1, n);
        wait_done("clean_after_sat", n, 3, 7, 0);
        // Back-to-back: start driven during the done cycle.
        start = 1'b1; div = 5'd2; quotient = 8'd3; remainder = 8'd1;
        @(posedge clock); #2;
        n = edge_cnt;
        start = 1'b0;
        check("b2b_busy", int'(busy), 1);
        check("b2b_hold_out", int'(outputval), 7);
        wait_done("b2b", n, 4, 7, 0);

        launch(4, 10, 2, n);
        #2;
        start = 1'b1; div = 5'd1; quotient = 8'd1; remainder = 8'd0;
        @(posedge clock); #2;
        start = 1'b0;
        wait_done("ignored_start", n, 11, 42, 0);
        count_dones(20, nd);
        check("no_second_done", nd, 0);

        launch(5, 20, 0, n);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_out", int'(outputval), 0);
        check("abort_ovf", int'(overflow), 0);
        @(posedge clock); #2 reset = 1'b0;
        count_dones(30, nd);
        check("abort_no_done", nd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
